// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and sizes for the I2S transmit/receive blocks
package i2s_pkg;
  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;
  localparam int I2S_DATA_W = 24;
  localparam int I2S_SLOT_W = 32;
  function automatic int cnt_w(input int slot_w);
    return $clog2(slot_w + 1);
  endfunction
  localparam int I2S_CNT_W = cnt_w(I2S_SLOT_W);
endpackage

// File: rtl/i2s_edge_sync.sv
// i2s_edge_sync: N-stage synchroniser for an async pin with rise/fall pulses
module i2s_edge_sync
  import i2s_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic              prev;
  // shift the pin through the synchroniser and keep one delayed copy for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      prev <= sync[STAGES-1];
    end
  end
  assign level = sync[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;
endmodule

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: serialises stereo sample pairs onto the DAC data pin, slaved to external bck/lrck (option: I2S_DAC_TX_HOLD_LAST_EN replays last pair on underrun)
module i2s_dac_tx
  import i2s_pkg::*;
#(
  parameter int   DATA_W      = I2S_DATA_W,
  parameter int   SLOT_W      = I2S_SLOT_W,
  parameter int   SYNC_STAGES = 2,
  parameter int   I2S_DELAY   = 1,
  parameter logic LEFT_LVL    = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_bck,
  input  logic              i_lrck,
  input  logic [DATA_W-1:0] i_left,
  input  logic [DATA_W-1:0] i_right,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_sdata,
  output logic              o_frame_start,
  output logic              o_underrun
);
  localparam int CNT_W = cnt_w(SLOT_W);
  localparam logic [CNT_W-1:0] DATA_N = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] SLOT_N = CNT_W'(SLOT_W);

  logic bck_lvl, bck_rise, bck_fall, lr, lr_rise, lr_fall, unused_edges;
  state_t state;
  logic prev_lr, hold_full, hold_full_nxt, accept, lr_chg, start, start_left;
  logic [CNT_W-1:0] cnt;
  logic [DATA_W-1:0] shreg, act_l, act_r, hold_l, hold_r, miss_l, miss_r, new_l, new_r, word;

  i2s_edge_sync #(.STAGES(SYNC_STAGES)) u_bck (
    .clk(clk), .rst_n(rst_n), .din(i_bck), .level(bck_lvl), .rise(bck_rise), .fall(bck_fall)
  );
  i2s_edge_sync #(.STAGES(SYNC_STAGES)) u_lrck (
    .clk(clk), .rst_n(rst_n), .din(i_lrck), .level(lr), .rise(lr_rise), .fall(lr_fall)
  );
  assign unused_edges = bck_lvl ^ bck_rise ^ lr_rise ^ lr_fall;

`ifdef I2S_DAC_TX_HOLD_LAST_EN
  assign miss_l = act_l;
  assign miss_r = act_r;
`else
  assign miss_l = '0;
  assign miss_r = '0;
`endif

  // slot starts, next active pair and holding-register occupancy
  always_comb begin
    accept        = i_valid & o_ready;
    lr_chg        = lr != prev_lr;
    start         = bck_fall & (state == IDLE ? (lr == LEFT_LVL) & lr_chg : lr_chg);
    start_left    = start & (lr == LEFT_LVL);
    new_l         = hold_full ? hold_l : miss_l;
    new_r         = hold_full ? hold_r : miss_r;
    word          = start_left ? new_l : act_r;
    hold_full_nxt = accept | (hold_full & ~start_left);
  end

  // handshake, slot sequencing and bit shifting, all advanced on detected bck falls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      prev_lr       <= LEFT_LVL;
      cnt           <= '0;
      shreg         <= '0;
      act_l         <= '0;
      act_r         <= '0;
      hold_l        <= '0;
      hold_r        <= '0;
      hold_full     <= 1'b0;
      o_ready       <= 1'b0;
      o_sdata       <= 1'b0;
      o_frame_start <= 1'b0;
      o_underrun    <= 1'b0;
    end else begin
      o_frame_start <= start_left;
      o_underrun    <= start_left & ~hold_full;
      hold_full     <= hold_full_nxt;
      o_ready       <= ~hold_full_nxt;
      if (accept) begin
        hold_l <= i_left;
        hold_r <= i_right;
      end
      if (start_left) begin
        act_l <= new_l;
        act_r <= new_r;
      end
      if (bck_fall) begin
        prev_lr <= lr;
        if (start) begin
          state <= start_left ? LEFT : RIGHT;
          if (I2S_DELAY != 0) begin
            shreg   <= word;
            cnt     <= '0;
            o_sdata <= 1'b0;
          end else begin
            shreg   <= word << 1;
            cnt     <= CNT_W'(1);
            o_sdata <= word[DATA_W-1];
          end
        end else if (state != IDLE) begin
          o_sdata <= (cnt < DATA_N) & shreg[DATA_W-1];
          shreg   <= shreg << 1;
          cnt     <= cnt == SLOT_N ? cnt : cnt + 1'b1;
        end
      end
    end
  end
endmodule
